// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time in clk cycles and flags a stuck line.
// Optional duty-cycle percentage divider enabled by defining PWM_CAPTURE_DUTY_PERCENT_EN.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
`ifdef PWM_CAPTURE_DUTY_PERCENT_EN
  ,
  output logic [6:0]       duty_pct,
  output logic             duty_valid
`endif
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {ARM, MEAS_HIGH, MEAS_LOW} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hi_lat;
  logic                   r_primed;
  state_t                 r_state;

  logic w_s, w_rise, w_fall, w_to;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  assign w_to   = (r_cnt == TO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d  <= w_s;
    end
  end

  // Cycles since the last rise; saturation at TO doubles as the timeout condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (w_rise)   r_cnt <= CNT_W'(1);
    else if (!w_to)    r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARM;
      r_primed   <= 1'b0;
      r_hi_lat   <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (w_rise) begin
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end
      case (r_state)
        ARM: begin
          if (w_rise) begin
            r_state  <= MEAS_HIGH;
            r_primed <= 1'b0;
          end else if (w_to && !stuck_high && !stuck_low) begin
            // Flags latch the level once and stay sticky until a rise.
            stuck_high <= w_s;
            stuck_low  <= ~w_s;
          end
        end
        MEAS_HIGH: begin
          if (w_rise) begin
            // A fall was lost; the period in flight cannot be trusted.
            r_primed <= 1'b0;
          end else if (w_fall) begin
            r_state  <= MEAS_LOW;
            r_hi_lat <= r_cnt;
          end else if (w_to) begin
            r_state    <= ARM;
            stuck_high <= w_s;
            stuck_low  <= ~w_s;
          end
        end
        MEAS_LOW: begin
          if (w_rise) begin
            r_state  <= MEAS_HIGH;
            r_primed <= 1'b1;
            if (r_primed) begin
              period     <= r_cnt;
              high_time  <= r_hi_lat;
              meas_valid <= 1'b1;
            end
          end else if (w_to) begin
            r_state    <= ARM;
            stuck_high <= w_s;
            stuck_low  <= ~w_s;
          end
        end
        default: r_state <= ARM;
      endcase
    end
  end

`ifdef PWM_CAPTURE_DUTY_PERCENT_EN
  localparam int DW = CNT_W + 7;

  logic [DW-1:0]    r_rem;
  logic [CNT_W-1:0] r_div;
  logic [2:0]       r_step;
  logic             r_busy;
  logic [6:0]       r_q;

  logic [DW-1:0] w_dsh;
  logic          w_ge;
  logic [6:0]    w_q_nxt;

  assign w_dsh   = DW'(r_div) << r_step;
  assign w_ge    = (r_rem >= w_dsh);
  assign w_q_nxt = r_q | (w_ge ? (7'd1 << r_step) : 7'd0);

  // Restoring division, one quotient bit per cycle from bit 6 down; a new
  // measurement restarts it so only complete results are published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem      <= '0;
      r_div      <= '0;
      r_step     <= '0;
      r_busy     <= 1'b0;
      r_q        <= '0;
      duty_pct   <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (meas_valid) begin
        r_busy <= 1'b1;
        r_step <= 3'd6;
        r_rem  <= DW'(high_time) * DW'(100);
        r_div  <= period;
        r_q    <= '0;
      end else if (r_busy) begin
        if (w_ge) r_rem <= r_rem - w_dsh;
        r_q <= w_q_nxt;
        if (r_step == 3'd0) begin
          r_busy     <= 1'b0;
          duty_pct   <= w_q_nxt;
          duty_valid <= 1'b1;
        end else begin
          r_step <= r_step - 3'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed PWM waveforms, a cycle-level reference model
// working from edge timestamps, and literal checks pinning key latencies and values.
`timescale 1ns/1ps
module tb_pwm_capture;
  localparam int CNT_W = 16;
  localparam int TO    = 1000;
  localparam int SS    = 2;

  logic clk = 1'b0, rst_n = 1'b0, pwm_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic meas_valid, stuck_high, stuck_low;
`ifdef PWM_CAPTURE_DUTY_PERCENT_EN
  logic [6:0] duty_pct;
  logic       duty_valid;
`endif

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .stuck_high(stuck_high), .stuck_low(stuck_low)
`ifdef PWM_CAPTURE_DUTY_PERCENT_EN
    , .duty_pct(duty_pct), .duty_valid(duty_valid)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int ph = 0;
  int v_cyc[$], v_per[$], v_hi[$], pin_rises[$];
  int sh_cyc = -1, sl_cyc = -1;
  bit p_sh = 0, p_sl = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive a continuous PWM: high while phase < h, phase wraps at p.
  task automatic run(input int n, input int p, input int h);
    bit nv;
    ph = ph % p;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      nv = (ph < h);
      if (nv && !pwm_in) pin_rises.push_back(cyc);
      pwm_in = nv;
      ph = (ph + 1) % p;
    end
  endtask

  function automatic int valid_delay(input int c);
    for (int i = 0; i < v_cyc.size(); i++) if (v_cyc[i] > c) return v_cyc[i] - c;
    return -1;
  endfunction

  function automatic int first_valid_idx(input int c);
    for (int i = 0; i < v_cyc.size(); i++) if (v_cyc[i] > c) return i;
    return -1;
  endfunction

  function automatic int vcount(input int a, input int b);
    int n = 0;
    for (int i = 0; i < v_cyc.size(); i++) if (v_cyc[i] >= a && v_cyc[i] < b) n++;
    return n;
  endfunction

  function automatic int first_rise_after(input int c);
    for (int i = 0; i < pin_rises.size(); i++) if (pin_rises[i] > c) return pin_rises[i];
    return -1;
  endfunction

  function automatic int last_per();
    return (v_per.size() > 0) ? v_per[v_per.size()-1] : -1;
  endfunction

  function automatic int last_hi();
    return (v_hi.size() > 0) ? v_hi[v_hi.size()-1] : -1;
  endfunction

  // Reference model: the synchronized line is the pin delayed SS cycles; measurements
  // are differences of edge timestamps; valid needs two clean periods in a row.
  bit rec[8];
  bit m_rst = 1, active, fell, clean;
  int anchor, fall_t, e_per, e_hi;
  bit e_mv, e_sh, e_sl;
`ifdef PWM_CAPTURE_DUTY_PERCENT_EN
  int d_due = -1, d_exp = 0, e_duty = 0;
`endif

  always @(negedge clk) begin : model
    bit s, sd, ok;
    int age;
    rec[cyc % 8] = rst_n ? pwm_in : 1'b0;
    if (!rst_n) begin
      m_rst = 1;
      ok = (period === '0 && high_time === '0 && meas_valid === 1'b0 &&
            stuck_high === 1'b0 && stuck_low === 1'b0);
`ifdef PWM_CAPTURE_DUTY_PERCENT_EN
      d_due = -1; e_duty = 0;
      ok = ok && (duty_pct === 7'd0) && (duty_valid === 1'b0);
`endif
      n_tests++;
      if (!ok) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL reset_outputs cycle %0d: outputs not zero in reset", cyc);
      end
    end else begin
      if (m_rst) begin
        m_rst = 0; anchor = cyc; active = 0; fell = 0; clean = 0; fall_t = 0;
        e_mv = 0; e_sh = 0; e_sl = 0; e_per = 0; e_hi = 0;
      end
      ok = (meas_valid === e_mv && period === e_per[CNT_W-1:0] &&
            high_time === e_hi[CNT_W-1:0] && stuck_high === e_sh && stuck_low === e_sl);
      n_tests++;
      if (!ok) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL model cycle %0d: mv/per/hi/sh/sl got %b/%0d/%0d/%b/%b expected %b/%0d/%0d/%b/%b",
                   cyc, meas_valid, period, high_time, stuck_high, stuck_low,
                   e_mv, e_per, e_hi, e_sh, e_sl);
      end
`ifdef PWM_CAPTURE_DUTY_PERCENT_EN
      if (cyc == d_due) e_duty = d_exp;
      n_tests++;
      if (duty_valid !== (cyc == d_due) || duty_pct !== e_duty[6:0]) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL duty cycle %0d: dv/pct got %b/%0d expected %b/%0d",
                   cyc, duty_valid, duty_pct, (cyc == d_due), e_duty);
      end
      if (e_mv) begin d_due = cyc + 8; d_exp = (e_hi * 100) / e_per; end
`endif
      if (meas_valid) begin
        v_cyc.push_back(cyc); v_per.push_back(int'(period)); v_hi.push_back(int'(high_time));
      end
      if (stuck_high && !p_sh) sh_cyc = cyc;
      if (stuck_low && !p_sl) sl_cyc = cyc;
      p_sh = stuck_high; p_sl = stuck_low;

      s   = rec[(cyc + 8 - SS) % 8];
      sd  = rec[(cyc + 8 - SS - 1) % 8];
      age = cyc - anchor;
      e_mv = 0;
      if (s && !sd) begin
        if (active && fell) begin
          if (clean) begin e_mv = 1; e_per = age; e_hi = fall_t - anchor; end
          clean = 1;
        end else clean = 0;
        active = 1; fell = 0; anchor = cyc; e_sh = 0; e_sl = 0;
      end else if (active) begin
        if (!s && sd) begin
          if (!fell) begin fell = 1; fall_t = cyc; end
        end else if (age >= TO) begin
          active = 0; e_sh = s; e_sl = !s;
        end
      end else if (age >= TO && !e_sh && !e_sl) begin
        e_sh = s; e_sl = !s;
      end
    end
  end

  initial begin
    int c0, s1, s2, s3, s3b, s4, s5, p, l, r1, idx;
    rst_n = 1'b0; pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_period", int'(period), 0);
    chk("reset_stuck_low", int'(stuck_low), 0);
    rst_n = 1'b1; c0 = cyc;

    // Constant low line after reset
    run(1010, 1, 0);
    chk("const_low_stuck_latency", sl_cyc - c0, TO + 1);

    // 101/20
    ph = 0; s1 = cyc;
    run(1010, 101, 20);
    p = first_rise_after(s1);
    chk("p1_first_valid_latency", valid_delay(p), 205);
    s2 = cyc;
    chk("p1_valid_count", vcount(s1, s2), 8);
    chk("p1_period", last_per(), 101);
    chk("p1_high", last_hi(), 20);
    chk("p1_stuck_low_cleared", int'(stuck_low), 0);
`ifdef PWM_CAPTURE_DUTY_PERCENT_EN
    chk("p1_duty_pct", int'(duty_pct), 19);
`endif

    // Threshold 80 mid-run
    run(1010, 101, 80);
    chk("p2_valid_count", vcount(s2, cyc + 1), 10);
    chk("p2_period", last_per(), 101);
    chk("p2_high", last_hi(), 80);
`ifdef PWM_CAPTURE_DUTY_PERCENT_EN
    chk("p2_duty_pct", int'(duty_pct), 79);
`endif

    // Stuck high, then resume
    s3 = cyc;
    run(1500, 1, 1);
    l = first_rise_after(s3);
    chk("p3_stuck_high_latency", sh_cyc - l, TO + 3);
    chk("p3_stuck_high", int'(stuck_high), 1);
    chk("p3_hold_period", int'(period), 101);
    chk("p3_hold_high", int'(high_time), 80);
    ph = 0; s3b = cyc;
    run(404, 101, 80);
    r1 = first_rise_after(s3b);
    chk("p3_resume_valid_latency", valid_delay(r1), 205);
    chk("p3_stuck_high_cleared", int'(stuck_high), 0);

    // Asynchronous reset mid-high, pin high at release
    run(10, 101, 20);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("p4_async_period", int'(period), 0);
    chk("p4_async_high", int'(high_time), 0);
    run(3, 101, 20);
    @(posedge clk); #1;
    rst_n = 1'b1; s4 = cyc;
    run(404, 101, 20);
    idx = first_valid_idx(s4);
    chk("p4_first_period", (idx >= 0) ? v_per[idx] : -1, 101);
    chk("p4_first_high", (idx >= 0) ? v_hi[idx] : -1, 20);

    // Single-cycle pulses every 5 cycles
    ph = 0;
    run(60, 5, 1);
    chk("p5_period", last_per(), 5);
    chk("p5_high", last_hi(), 1);

    // Period equal to TIMEOUT: edge and timeout coincide
    ph = 0; s5 = cyc;
    run(3010, TO, 10);
    chk("p6_valid_count", vcount(s5, cyc + 1), 4);
    chk("p6_period", last_per(), TO);
    chk("p6_high", last_hi(), 10);
    chk("p6_stuck_high", int'(stuck_high), 0);
    chk("p6_stuck_low", int'(stuck_low), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
